// File: rtl/time_set_ctrl.sv
// Time-set controller for a 24-hour BCD clock.
// Turns debounced Mode/Up/Down buttons into an edited HH:MM value with
// single-step and auto-repeat, then loads it into the clock with a one-cycle
// strobe. The field being edited blinks through BlinkMask.
module time_set_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       BtnMode,
  input  logic       BtnUp,
  input  logic       BtnDown,
  input  logic [3:0] CurHoursTens,
  input  logic [3:0] CurHoursUnits,
  input  logic [3:0] CurMinutesTens,
  input  logic [3:0] CurMinutesUnits,
  output logic [3:0] SetHoursTens,
  output logic [3:0] SetHoursUnits,
  output logic [3:0] SetMinutesTens,
  output logic [3:0] SetMinutesUnits,
  output logic       Load,
  output logic       Editing,
  output logic [3:0] BlinkMask
);

  localparam logic [29:0] HOLD_L    = 30'(HOLD_CYCLES);
  localparam logic [29:0] REPEAT_L  = 30'(REPEAT_CYCLES);
  localparam logic [29:0] BLINK_L   = 30'(BLINK_CYCLES);
  localparam logic [29:0] TIMEOUT_L = 30'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {RUN, EDIT_HOURS, EDIT_MINUTES, COMMIT} state_t;

  state_t      state;
  logic        mode_prev, up_prev, down_prev;
  logic [29:0] hold_cnt, timeout_cnt, blink_cnt;
  logic        repeating, blink_off;

  logic        mode_rise, up_rise, down_rise, any_rise, in_edit;
  logic        held_up, held_down, held_one, held_rise, hold_hit;
  logic        step_up, step_down, timeout_hit, blink_wrap, blink_off_nxt;
  logic [29:0] hold_limit;

  // BCD hours 00-23, wrapping both ways.
  function automatic logic [7:0] hours_up(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hours_down(input logic [7:0] v);
    if (v == 8'h00)          return 8'h23;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // BCD minutes 00-59, wrapping without touching hours.
  function automatic logic [7:0] minutes_up(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] minutes_down(input logic [7:0] v);
    if (v == 8'h00)          return 8'h59;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Edge detection, step generation (rise or auto-repeat) and timer compares.
  always_comb begin
    mode_rise     = BtnMode & ~mode_prev;
    up_rise       = BtnUp & ~up_prev;
    down_rise     = BtnDown & ~down_prev;
    any_rise      = mode_rise | up_rise | down_rise;
    in_edit       = (state == EDIT_HOURS) || (state == EDIT_MINUTES);
    held_up       = BtnUp & ~BtnDown;
    held_down     = BtnDown & ~BtnUp;
    held_one      = held_up | held_down;
    held_rise     = (held_up & up_rise) | (held_down & down_rise);
    // The first auto step waits HOLD cycles after the press, later ones REPEAT.
    hold_limit    = repeating ? REPEAT_L : HOLD_L;
    hold_hit      = held_one & ~held_rise & ((hold_cnt + 30'd1) == hold_limit);
    step_up       = in_edit & held_up & (up_rise | hold_hit);
    step_down     = in_edit & held_down & (down_rise | hold_hit);
    timeout_hit   = in_edit & ((timeout_cnt + 30'd1) == TIMEOUT_L);
    blink_wrap    = (blink_cnt + 30'd1) == BLINK_L;
    blink_off_nxt = blink_off ^ blink_wrap;
  end

  // Edit FSM with button history, timers and registered outputs.
  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      state           <= RUN;
      mode_prev       <= 1'b0;
      up_prev         <= 1'b0;
      down_prev       <= 1'b0;
      hold_cnt        <= '0;
      repeating       <= 1'b0;
      timeout_cnt     <= '0;
      blink_cnt       <= '0;
      blink_off       <= 1'b0;
      SetHoursTens    <= 4'd0;
      SetHoursUnits   <= 4'd0;
      SetMinutesTens  <= 4'd0;
      SetMinutesUnits <= 4'd0;
      Load            <= 1'b0;
      Editing         <= 1'b0;
      BlinkMask       <= 4'b0000;
    end else begin
      mode_prev <= BtnMode;
      up_prev   <= BtnUp;
      down_prev <= BtnDown;
      Load      <= 1'b0;

      // A fresh press restarts the hold delay; both or neither held clears it.
      if (in_edit && held_one && !held_rise && !hold_hit) hold_cnt <= hold_cnt + 30'd1;
      else                                                hold_cnt <= '0;
      if (in_edit && held_one && !held_rise) repeating <= repeating | hold_hit;
      else                                   repeating <= 1'b0;

      // Blink runs freely; entering an edit state restarts it in the "on" phase.
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 30'd1;
      blink_off <= blink_off_nxt;

      case (state)
        RUN: begin
          Editing   <= 1'b0;
          BlinkMask <= 4'b0000;
          if (mode_rise) begin
            SetHoursTens    <= CurHoursTens;
            SetHoursUnits   <= CurHoursUnits;
            SetMinutesTens  <= CurMinutesTens;
            SetMinutesUnits <= CurMinutesUnits;
            state           <= EDIT_HOURS;
            Editing         <= 1'b1;
            timeout_cnt     <= '0;
            blink_cnt       <= '0;
            blink_off       <= 1'b0;
          end
        end
        EDIT_HOURS: begin
          if (mode_rise) begin
            state       <= EDIT_MINUTES;
            timeout_cnt <= '0;
            blink_cnt   <= '0;
            blink_off   <= 1'b0;
            BlinkMask   <= 4'b0000;
          end else if (timeout_hit) begin
            state     <= RUN;
            Editing   <= 1'b0;
            BlinkMask <= 4'b0000;
          end else begin
            if (step_up)
              {SetHoursTens, SetHoursUnits} <= hours_up({SetHoursTens, SetHoursUnits});
            else if (step_down)
              {SetHoursTens, SetHoursUnits} <= hours_down({SetHoursTens, SetHoursUnits});
            timeout_cnt <= (any_rise || step_up || step_down) ? '0 : timeout_cnt + 30'd1;
            BlinkMask   <= blink_off_nxt ? 4'b1100 : 4'b0000;
          end
        end
        EDIT_MINUTES: begin
          if (mode_rise) begin
            state     <= COMMIT;
            Load      <= 1'b1;
            BlinkMask <= 4'b0000;
          end else if (timeout_hit) begin
            state     <= RUN;
            Editing   <= 1'b0;
            BlinkMask <= 4'b0000;
          end else begin
            if (step_up)
              {SetMinutesTens, SetMinutesUnits} <= minutes_up({SetMinutesTens, SetMinutesUnits});
            else if (step_down)
              {SetMinutesTens, SetMinutesUnits} <= minutes_down({SetMinutesTens, SetMinutesUnits});
            timeout_cnt <= (any_rise || step_up || step_down) ? '0 : timeout_cnt + 30'd1;
            BlinkMask   <= blink_off_nxt ? 4'b0011 : 4'b0000;
          end
        end
        COMMIT: begin
          state     <= RUN;
          Editing   <= 1'b0;
          BlinkMask <= 4'b0000;
        end
        default: begin
          state     <= RUN;
          Editing   <= 1'b0;
          BlinkMask <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl with shortened timing parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode, btn_up, btn_down;
  logic [3:0] cur_ht, cur_hu, cur_mt, cur_mu;
  logic [3:0] set_ht, set_hu, set_mt, set_mu;
  logic       load, editing;
  logic [3:0] blink_mask;
  logic [15:0] set_val;

  int n_cmp  = 0;
  int n_fail = 0;

  assign set_val = {set_ht, set_hu, set_mt, set_mu};

  time_set_ctrl #(
    .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .BLINK_CYCLES(5), .TIMEOUT_CYCLES(20)
  ) dut (
    .Clk_100M(clk), .Reset(reset_n),
    .BtnMode(btn_mode), .BtnUp(btn_up), .BtnDown(btn_down),
    .CurHoursTens(cur_ht), .CurHoursUnits(cur_hu),
    .CurMinutesTens(cur_mt), .CurMinutesUnits(cur_mu),
    .SetHoursTens(set_ht), .SetHoursUnits(set_hu),
    .SetMinutesTens(set_mt), .SetMinutesUnits(set_mu),
    .Load(load), .Editing(editing), .BlinkMask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_ht, cur_hu, cur_mt, cur_mu} = v;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      btn_up = 1'b1; cyc(1); btn_up = 1'b0; cyc(1);
    end
  endtask

  task automatic press_down(input int n);
    for (int i = 0; i < n; i++) begin
      btn_down = 1'b1; cyc(1); btn_down = 1'b0; cyc(1);
    end
  endtask

  task automatic test_reset();
    logic load_seen;
    reset_n = 1'b0;
    cyc(2);
    n_cmp++;
    if ({set_val, load, editing, blink_mask} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state: set=%h load=%b editing=%b mask=%b, want all zero",
               set_val, load, editing, blink_mask);
    end
    reset_n = 1'b1;
    set_cur(16'h1234);
    press_mode();
    press_mode();
    n_cmp++;
    if ({editing, set_val} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL reset_setup: editing=%b set=%h, want 1 1234", editing, set_val);
    end
    load_seen = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      if (load) load_seen = 1'b1;
    end
    reset_n = 1'b1;
    cyc(1);
    if (load) load_seen = 1'b1;
    n_cmp++;
    if ({set_val, load_seen, editing, blink_mask} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_midedit: set=%h load_seen=%b editing=%b mask=%b, want all zero",
               set_val, load_seen, editing, blink_mask);
    end
    press_up(1);
    n_cmp++;
    if (set_val !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_run_ignores_up: set=%h, want 0000", set_val);
    end
    btn_mode = 1'b1; cyc(1); btn_mode = 1'b0;
    n_cmp++;
    if ({editing, set_val} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL reset_recapture: editing=%b set=%h, want 1 1234", editing, set_val);
    end
    cyc(1);
    press_mode();
    press_mode();
  endtask

  task automatic test_basic_edit();
    int loads;
    set_cur(16'h1437);
    btn_mode = 1'b1; cyc(1);
    n_cmp++;
    if ({editing, load, set_val} !== {2'b10, 16'h1437}) begin
      n_fail++;
      $display("FAIL basic_capture: editing=%b load=%b set=%h, want 1 0 1437", editing, load, set_val);
    end
    btn_mode = 1'b0; cyc(1);
    press_up(3);
    n_cmp++;
    if (set_val !== 16'h1737) begin
      n_fail++;
      $display("FAIL basic_up3: set=%h, want 1737", set_val);
    end
    press_mode();
    press_down(40);
    n_cmp++;
    if (set_val !== 16'h1757) begin
      n_fail++;
      $display("FAIL basic_down40: set=%h, want 1757", set_val);
    end
    loads = 0;
    btn_mode = 1'b1; cyc(1);
    n_cmp++;
    if ({load, editing, set_val} !== {2'b11, 16'h1757}) begin
      n_fail++;
      $display("FAIL basic_commit: load=%b editing=%b set=%h, want 1 1 1757", load, editing, set_val);
    end
    if (load) loads++;
    btn_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (load) loads++;
    end
    n_cmp++;
    if ({editing, blink_mask} !== 5'd0 || loads != 1) begin
      n_fail++;
      $display("FAIL basic_back_to_run: editing=%b mask=%b loads=%0d, want 0 0000 1",
               editing, blink_mask, loads);
    end
  endtask

  task automatic test_wrap();
    set_cur(16'h2359);
    press_mode();
    press_up(1);
    n_cmp++;
    if (set_val !== 16'h0059) begin n_fail++; $display("FAIL wrap_h23_up: set=%h, want 0059", set_val); end
    press_down(1);
    n_cmp++;
    if (set_val !== 16'h2359) begin n_fail++; $display("FAIL wrap_h00_down: set=%h, want 2359", set_val); end
    press_down(4);
    n_cmp++;
    if (set_val !== 16'h1959) begin n_fail++; $display("FAIL wrap_h20_down: set=%h, want 1959", set_val); end
    press_down(10);
    n_cmp++;
    if (set_val !== 16'h0959) begin n_fail++; $display("FAIL wrap_h10_down: set=%h, want 0959", set_val); end
    press_up(1);
    n_cmp++;
    if (set_val !== 16'h1059) begin n_fail++; $display("FAIL wrap_h09_up: set=%h, want 1059", set_val); end
    press_up(10);
    n_cmp++;
    if (set_val !== 16'h2059) begin n_fail++; $display("FAIL wrap_h19_up: set=%h, want 2059", set_val); end
    press_mode();
    press_up(1);
    n_cmp++;
    if (set_val !== 16'h2000) begin n_fail++; $display("FAIL wrap_m59_up: set=%h, want 2000", set_val); end
    press_up(10);
    n_cmp++;
    if (set_val !== 16'h2010) begin n_fail++; $display("FAIL wrap_m09_up: set=%h, want 2010", set_val); end
    press_down(1);
    n_cmp++;
    if (set_val !== 16'h2009) begin n_fail++; $display("FAIL wrap_m10_down: set=%h, want 2009", set_val); end
    press_up(11);
    press_down(1);
    n_cmp++;
    if (set_val !== 16'h2019) begin n_fail++; $display("FAIL wrap_m20_down: set=%h, want 2019", set_val); end
    press_down(20);
    n_cmp++;
    if (set_val !== 16'h2059) begin n_fail++; $display("FAIL wrap_m00_down: set=%h, want 2059", set_val); end
    btn_mode = 1'b1; cyc(1);
    n_cmp++;
    if ({load, set_val} !== {1'b1, 16'h2059}) begin
      n_fail++;
      $display("FAIL wrap_commit: load=%b set=%h, want 1 2059", load, set_val);
    end
    btn_mode = 1'b0; cyc(1);
  endtask

  task automatic test_auto_repeat();
    set_cur(16'h0000);
    press_mode();
    press_mode();
    btn_up = 1'b1; cyc(1);
    n_cmp++;
    if (set_val !== 16'h0001) begin n_fail++; $display("FAIL rep_rise: set=%h, want 0001", set_val); end
    cyc(9);
    n_cmp++;
    if (set_val !== 16'h0001) begin n_fail++; $display("FAIL rep_before_hold: set=%h, want 0001", set_val); end
    cyc(1);
    n_cmp++;
    if (set_val !== 16'h0002) begin n_fail++; $display("FAIL rep_hold10: set=%h, want 0002", set_val); end
    cyc(3);
    n_cmp++;
    if (set_val !== 16'h0002) begin n_fail++; $display("FAIL rep_before14: set=%h, want 0002", set_val); end
    cyc(1);
    n_cmp++;
    if (set_val !== 16'h0003) begin n_fail++; $display("FAIL rep_cycle14: set=%h, want 0003", set_val); end
    cyc(16);
    n_cmp++;
    if (set_val !== 16'h0007) begin n_fail++; $display("FAIL rep_cycle30: set=%h, want 0007", set_val); end
    btn_up = 1'b0; cyc(1);
    n_cmp++;
    if (set_val !== 16'h0007) begin n_fail++; $display("FAIL rep_release: set=%h, want 0007", set_val); end
    btn_up = 1'b1; cyc(1);
    cyc(10);
    n_cmp++;
    if (set_val !== 16'h0009) begin n_fail++; $display("FAIL rep_second_hold: set=%h, want 0009", set_val); end
    cyc(3);
    btn_down = 1'b1; cyc(1);
    n_cmp++;
    if (set_val !== 16'h0009) begin n_fail++; $display("FAIL rep_both_stop: set=%h, want 0009", set_val); end
    cyc(10);
    n_cmp++;
    if (set_val !== 16'h0009) begin n_fail++; $display("FAIL rep_both_hold: set=%h, want 0009", set_val); end
    btn_up = 1'b0; btn_down = 1'b0; cyc(1);
    press_mode();
  endtask

  task automatic test_timeout();
    logic load_seen;
    set_cur(16'h0506);
    btn_mode = 1'b1; cyc(1);
    btn_mode = 1'b0;
    n_cmp++;
    if ({editing, set_val} !== {1'b1, 16'h0506}) begin
      n_fail++;
      $display("FAIL to_capture: editing=%b set=%h, want 1 0506", editing, set_val);
    end
    btn_up = 1'b1; cyc(1); btn_up = 1'b0;
    n_cmp++;
    if (set_val !== 16'h0606) begin n_fail++; $display("FAIL to_step: set=%h, want 0606", set_val); end
    load_seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cyc(1);
      if (load) load_seen = 1'b1;
      if (i == 3) begin
        n_cmp++;
        if (blink_mask !== 4'b1100) begin
          n_fail++;
          $display("FAIL to_blink_hours_off: mask=%b, want 1100", blink_mask);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (blink_mask !== 4'b0000) begin
          n_fail++;
          $display("FAIL to_blink_hours_on: mask=%b, want 0000", blink_mask);
        end
      end
    end
    n_cmp++;
    if (editing !== 1'b1) begin n_fail++; $display("FAIL to_not_early: editing=%b, want 1", editing); end
    cyc(1);
    if (load) load_seen = 1'b1;
    n_cmp++;
    if ({editing, load_seen, blink_mask, set_val} !== {6'b000000, 16'h0606}) begin
      n_fail++;
      $display("FAIL to_expire: editing=%b load_seen=%b mask=%b set=%h, want 0 0 0000 0606",
               editing, load_seen, blink_mask, set_val);
    end
    set_cur(16'h1122);
    btn_mode = 1'b1; cyc(1);
    n_cmp++;
    if ({editing, set_val} !== {1'b1, 16'h1122}) begin
      n_fail++;
      $display("FAIL to_recapture: editing=%b set=%h, want 1 1122", editing, set_val);
    end
    btn_mode = 1'b0; cyc(1);
  endtask

  task automatic test_mode_up_blink();
    logic [3:0] exp_mask;
    press_down(3);
    n_cmp++;
    if (set_val !== 16'h0822) begin n_fail++; $display("FAIL mu_setup: set=%h, want 0822", set_val); end
    btn_mode = 1'b1; btn_up = 1'b1; cyc(1);
    btn_mode = 1'b0; btn_up = 1'b0;
    n_cmp++;
    if ({editing, blink_mask, set_val} !== {5'b10000, 16'h0822}) begin
      n_fail++;
      $display("FAIL mu_same_cycle: editing=%b mask=%b set=%h, want 1 0000 0822",
               editing, blink_mask, set_val);
    end
    for (int i = 1; i < 20; i++) begin
      cyc(1);
      exp_mask = (((i / 5) % 2) == 1) ? 4'b0011 : 4'b0000;
      n_cmp++;
      if (blink_mask !== exp_mask) begin
        n_fail++;
        $display("FAIL mu_blink_%0d: mask=%b, want %b", i, blink_mask, exp_mask);
      end
    end
    n_cmp++;
    if (set_val !== 16'h0822) begin n_fail++; $display("FAIL mu_hold_value: set=%h, want 0822", set_val); end
    cyc(1);
    n_cmp++;
    if ({editing, load, blink_mask} !== 6'd0) begin
      n_fail++;
      $display("FAIL mu_timeout: editing=%b load=%b mask=%b, want 0 0 0000", editing, load, blink_mask);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    set_cur(16'h0000);
    test_reset();
    test_basic_edit();
    test_wrap();
    test_auto_repeat();
    test_timeout();
    test_mode_up_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-input side of the 24-hour BCD clock: turns debounced pushbuttons into a new HH:MM value and loads it into the clock counters.
- Captures the running time, lets the user edit hours, then minutes, with single-step and auto-repeat, then issues a one-cycle load strobe.
- Drives a blink mask to the seven-segment driver so the field being edited flashes.

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles a button is held before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_CYCLES, default 10_000_000: cycles between auto-repeat steps (0.1 s).
- BLINK_CYCLES, default 25_000_000: half-period of the blink toggle.
- TIMEOUT_CYCLES, default 1_000_000_000: cycles with no button activity in edit before the edit is abandoned (10 s). Counter width is 30 bits.

Ports:
- Clk_100M  in  1  system clock, 100 MHz.
- Reset  in  1  synchronous, active-low reset.
- BtnMode  in  1  debounced, active-high, level.
- BtnUp  in  1  debounced, active-high, level.
- BtnDown  in  1  debounced, active-high, level.
- CurHoursTens, CurHoursUnits, CurMinutesTens, CurMinutesUnits  in  4 each  live BCD time from the clock.
- SetHoursTens, SetHoursUnits, SetMinutesTens, SetMinutesUnits  out  4 each  shadow BCD time being edited.
- Load  out  1  one-cycle strobe: clock copies the Set* digits and zeroes its seconds on this edge.
- Editing  out  1  high in every state except RUN; the clock holds its counters while this is high.
- BlinkMask  out  4  digit blank enables, bit3 = hours tens … bit0 = minutes units.

Behaviour:
- Reset (Reset == 0 at a clock edge):
  - state RUN; all Set* = 0; Load = 0; Editing = 0; BlinkMask = 0.
  - All timers and edge registers cleared; previous button samples = 0.
  - Applies mid-edit: the edit is discarded and no Load is issued.
- Edge detect: registered previous sample of each button; a rise is current & ~previous. The first response comes one cycle after the input goes high.
- FSM states: RUN, EDIT_HOURS, EDIT_MINUTES, COMMIT.
  - RUN: on Mode rise, copy the Cur* digits into Set*, then go to EDIT_HOURS.
  - EDIT_HOURS: on Mode rise, go to EDIT_MINUTES.
  - EDIT_MINUTES: on Mode rise, go to COMMIT.
  - COMMIT: lasts exactly one cycle with Load = 1, then returns to RUN. Load is never high in any other state.
  - In either edit state, if the timeout counter reaches TIMEOUT_CYCLES, return to RUN with no Load. Set* keep their values.
- Precedence within a cycle: Reset > Mode rise > timeout > Up/Down. A Mode rise in the same cycle as an Up or Down rise ignores the Up/Down.
- Step events, active only in edit states:
  - Up rise gives +1; Down rise gives −1.
  - While exactly one of Up/Down stays high, a hold counter runs. At HOLD_CYCLES it issues a step, then another step every REPEAT_CYCLES.
  - Release, or both buttons high, clears the hold counter. Both high produces no step.
- Hours arithmetic (BCD, 00–23, wraps):
  - Up: 09→10, 19→20, 23→00.
  - Down: 00→23, 10→09, 20→19.
- Minutes arithmetic (BCD, 00–59, wraps): 59→00 on Up, 00→59 on Down. Minutes never carry into or borrow from hours.
- Set* outputs are always legal BCD. Digits captured from Cur* are assumed legal.
- Timeout counter: cleared on entry to an edit state and on any button rise or step; otherwise increments while in an edit state.
- Blink phase:
  - The blink counter toggles the phase every BLINK_CYCLES and is reset to phase "on" on entry to each edit state.
  - BlinkMask = 4'b1100 in EDIT_HOURS during the "off" phase.
  - BlinkMask = 4'b0011 in EDIT_MINUTES during the "off" phase.
  - BlinkMask = 0 in every other state or phase.
- Editing = 1 in EDIT_HOURS, EDIT_MINUTES and COMMIT.
- All outputs are registered.

Test Plan:
- Reset low for 2 cycles while in EDIT_MINUTES → next cycle: state RUN, Set* = 0, Load never pulses, Editing = 0, BlinkMask = 0.
- Cur = 14:37, Mode rise → Set = 14:37, Editing = 1. Up ×3 → 17:37. Mode, Down ×40 (single rises) → 17:57. Mode → exactly one Load = 1 cycle with Set = 17:57, then RUN.
- Hours wrap: start 23, Up → 00; Down → 23. Minutes wrap: start 59, Up → 00 with hours unchanged; 09 Up → 10; 20 Down → 19.
- Auto-repeat with HOLD_CYCLES = 10, REPEAT_CYCLES = 4: hold Up 30 cycles in EDIT_MINUTES from 00 → steps at the rise, cycle 10, 14, 18, 22, 26, 30, giving 07. Asserting Down as well mid-hold → stepping stops immediately.
- Timeout with TIMEOUT_CYCLES = 20: enter edit, idle 20 cycles → RUN with no Load. Set* unchanged; next Mode rise recaptures Cur*.
- Same-cycle Mode and Up rise in EDIT_HOURS at 08 → moves to EDIT_MINUTES, hours stay 08. With BLINK_CYCLES = 5, BlinkMask shows 0000 for 5 cycles, then 0011 for 5 cycles, alternating.
